// File: rtl/cam_pkg.sv
// cam_pkg: shared definitions for the camera colour path.
//   - RGB565 field positions (green taken as its upper 5 bits G[5:1])
//   - one-hot colour encodings, identical to the led[2:0] encoding
//   - FSM state encoding for color_frame_class
//   - dom_t / dom_gt: per-pixel dominance flags and the margin compare
package cam_pkg;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 6;    // G[5:1] of the 6-bit green field
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    localparam logic [2:0] COL_R    = 3'b100;
    localparam logic [2:0] COL_G    = 3'b010;
    localparam logic [2:0] COL_B    = 3'b001;
    localparam logic [2:0] COL_NONE = 3'b000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DECIDE = 2'd3;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } dom_t;

    // x > y + margin on 6 bits, so y + margin cannot wrap on the 5-bit scale.
    function automatic logic dom_gt(input logic [4:0] x, input logic [4:0] y,
                                    input logic [5:0] margin);
        return {1'b0, x} > ({1'b0, y} + margin);
    endfunction

endpackage

// File: rtl/color_dom_pix.sv
// color_dom_pix: per-pixel dominance pipeline (stages 1-2).
//   stage 1 registers the 5-bit R/G/B components, stage 2 registers the
//   one-hot dominance flags. At most one flag can be set per pixel.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           drops every pixel in flight (frame abort / restart)
//   in_valid        pixel qualifier, already gated by the caller's FSM
//   pixel_data      RGB565 pixel
//   out_valid       stage-2 valid
//   dom             {r,g,b} dominance flags for the stage-2 pixel
module color_dom_pix
    import cam_pkg::*;
#(
    parameter int MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] pixel_data,
    output logic        out_valid,
    output logic [2:0]  dom
);

    localparam int         STAGES  = 2;
    localparam logic [5:0] MARGIN6 = 6'(MARGIN);

    logic [STAGES:1] vld_pipe;
    logic [4:0]      r_q, g_q, b_q;
    dom_t            dom_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            dom_q    <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            r_q      <= pixel_data[R_HI:R_LO];
            g_q      <= pixel_data[G_HI:G_LO];
            b_q      <= pixel_data[B_HI:B_LO];
            dom_q.r  <= dom_gt(r_q, g_q, MARGIN6) && dom_gt(r_q, b_q, MARGIN6);
            dom_q.g  <= dom_gt(g_q, r_q, MARGIN6) && dom_gt(g_q, b_q, MARGIN6);
            dom_q.b  <= dom_gt(b_q, r_q, MARGIN6) && dom_gt(b_q, g_q, MARGIN6);
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign dom       = dom_q;

endmodule

// File: rtl/color_frame_class.sv
// color_frame_class: per-frame colour classifier.
//   Counts red/green/blue dominant pixels over a frame and, at frame end,
//   publishes the one-hot winner through a valid/ready handshake.
// Ports:
//   p_clock, rst    pixel clock, asynchronous active-low reset
//   frame_start     frame start pulse (also aborts a frame in progress)
//   pixel_valid     pixel_data qualifier
//   pixel_data      RGB565 pixel
//   frame_done      pulse after the last pixel of a frame
//   res_ready       downstream accepts the result
//   res_valid       result available, held until accepted
//   color_code      one-hot {R,G,B}, 3'b000 = no dominant colour
//   color_count     winning class count (0 when color_code is 0)
//   busy            frame in progress (ACCUM/DRAIN/DECIDE)
//   overrun         sticky: an unaccepted result was overwritten
module color_frame_class
    import cam_pkg::*;
#(
    parameter int CNT_W   = 17,
    parameter int MARGIN  = 2,
    parameter int MIN_PIX = 1024
) (
    input  logic             p_clock,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pixel_valid,
    input  logic [15:0]      pixel_data,
    input  logic             frame_done,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [2:0]       color_code,
    output logic [CNT_W-1:0] color_count,
    output logic             busy,
    output logic             overrun
);

    localparam logic [31:0] MIN_V = 32'(MIN_PIX);

    logic [1:0]       state;
    logic             drain_cnt;
    logic             pix_in;
    logic             dom_valid;
    logic [2:0]       dom;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b;
    logic [2:0]       win_code;
    logic [CNT_W-1:0] win_cnt;

    // Pixels enter only while accumulating; a frame_start in the same cycle
    // wins because it flushes the pipeline anyway.
    assign pix_in = pixel_valid && (state == ST_ACCUM) && !frame_start;

    color_dom_pix #(.MARGIN(MARGIN)) u_dom (
        .clk        (p_clock),
        .rst        (rst),
        .flush      (frame_start),
        .in_valid   (pix_in),
        .pixel_data (pixel_data),
        .out_valid  (dom_valid),
        .dom        (dom)
    );

    // Stage 3: saturating class counters. frame_start restarts the frame
    // from any state, so it clears unconditionally.
    always_ff @(posedge p_clock or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (frame_start) begin
            cnt_r <= '0;
            cnt_g <= '0;
            cnt_b <= '0;
        end else if (dom_valid) begin
            if (dom[2] && (cnt_r != '1)) cnt_r <= cnt_r + 1'b1;
            if (dom[1] && (cnt_g != '1)) cnt_g <= cnt_g + 1'b1;
            if (dom[0] && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
        end
    end

    // Winner: strictly greater than both others and at least MIN_PIX.
    always_comb begin
        win_code = COL_NONE;
        win_cnt  = '0;
        if (cnt_r > cnt_g && cnt_r > cnt_b && 32'(cnt_r) >= MIN_V) begin
            win_code = COL_R;
            win_cnt  = cnt_r;
        end else if (cnt_g > cnt_r && cnt_g > cnt_b && 32'(cnt_g) >= MIN_V) begin
            win_code = COL_G;
            win_cnt  = cnt_g;
        end else if (cnt_b > cnt_r && cnt_b > cnt_g && 32'(cnt_b) >= MIN_V) begin
            win_code = COL_B;
            win_cnt  = cnt_b;
        end
    end

    // DRAIN lasts two cycles so the last pixel (taken with frame_done)
    // has reached the counters before DECIDE looks at them.
    always_ff @(posedge p_clock or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (!frame_start && frame_done) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (frame_start)    state     <= ST_ACCUM;
                    else if (drain_cnt) state     <= ST_DECIDE;
                    else                drain_cnt <= 1'b1;
                end
                ST_DECIDE: begin
                    state <= frame_start ? ST_ACCUM : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result register: DECIDE always publishes; otherwise a transfer drops
    // res_valid and leaves the last code/count in place.
    always_ff @(posedge p_clock or negedge rst) begin
        if (!rst) begin
            res_valid   <= 1'b0;
            color_code  <= COL_NONE;
            color_count <= '0;
            overrun     <= 1'b0;
        end else if (state == ST_DECIDE) begin
            res_valid   <= 1'b1;
            color_code  <= win_code;
            color_count <= win_cnt;
            if (res_valid && !res_ready) overrun <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
